// File: rtl/i2s_tx_channel.sv
// I2S slave transmit channel: serialises 32-bit FIFO words onto one or
// two data lines, timed by the master's WS and SCK (falling-edge flops).
module i2s_tx_channel (
    input  logic        sck_i,
    input  logic        rstn_i,
    input  logic [31:0] fifo_data_i,
    input  logic        fifo_data_valid_i,
    output logic        fifo_data_ready_o,
    output logic        fifo_err_o,
    input  logic        i2s_ws_i,
    output logic        i2s_ch0_o,
    output logic        i2s_ch1_o,
    input  logic        cfg_en_i,
    input  logic        cfg_2ch_i,
    input  logic [4:0]  cfg_wlen_i,
    input  logic        cfg_lsb_first_i
);

    logic [1:0]  r_ws_sync;
    logic        r_started;
    logic [4:0]  r_count_bit;
    logic [31:0] r_shift_ch0;
    logic [31:0] r_shift_ch1;
    logic [31:0] r_hold;

    logic        w_ws_edge;
    logic [4:0]  w_wlen_m1;
    logic        w_pop0;
    logic        w_pop1;
    logic        w_load;
    logic [31:0] w_word;

    assign w_ws_edge = r_ws_sync[1] ^ r_ws_sync[0];
    assign w_wlen_m1 = cfg_wlen_i - 5'd1;

    // In stereo the ch0 word is popped one cycle ahead so both lines load together
    assign w_pop0 = r_started &
                    (cfg_2ch_i ? (r_count_bit == w_wlen_m1)
                               : (r_count_bit == cfg_wlen_i));
    assign w_pop1 = r_started & cfg_2ch_i & (r_count_bit == cfg_wlen_i);
    assign w_load = cfg_2ch_i ? w_pop1 : w_pop0;

    // An empty FIFO yields a zero word so the slot still goes out on time
    assign w_word = fifo_data_valid_i ? fifo_data_i : 32'd0;

    assign fifo_data_ready_o = w_pop0 | w_pop1;
    assign fifo_err_o        = fifo_data_ready_o & ~fifo_data_valid_i;

    assign i2s_ch0_o = cfg_lsb_first_i ? r_shift_ch0[0]
                                       : r_shift_ch0[cfg_wlen_i];
    assign i2s_ch1_o = cfg_2ch_i &
                       (cfg_lsb_first_i ? r_shift_ch1[0]
                                        : r_shift_ch1[cfg_wlen_i]);

    // Synchronise WS and latch the enable only at WS transitions
    always_ff @(negedge sck_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_ws_sync <= 2'b00;
            r_started <= 1'b0;
        end else begin
            r_ws_sync <= {r_ws_sync[0], i2s_ws_i};
            if (w_ws_edge) begin
                r_started <= cfg_en_i;
            end
        end
    end

    // Free-running bit counter; idle preset makes the first pop follow start
    always_ff @(negedge sck_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_count_bit <= 5'd0;
        end else if (!r_started) begin
            r_count_bit <= cfg_2ch_i ? w_wlen_m1 : cfg_wlen_i;
        end else if (r_count_bit == cfg_wlen_i) begin
            r_count_bit <= 5'd0;
        end else begin
            r_count_bit <= r_count_bit + 5'd1;
        end
    end

    // Load words at pop points, otherwise shift towards the active output bit
    always_ff @(negedge sck_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_shift_ch0 <= 32'd0;
            r_shift_ch1 <= 32'd0;
            r_hold      <= 32'd0;
        end else if (!r_started) begin
            r_shift_ch0 <= 32'd0;
            r_shift_ch1 <= 32'd0;
            r_hold      <= 32'd0;
        end else begin
            if (w_pop0 && cfg_2ch_i) begin
                r_hold <= w_word;
            end
            if (w_load) begin
                r_shift_ch0 <= cfg_2ch_i ? r_hold : w_word;
                r_shift_ch1 <= cfg_2ch_i ? w_word : 32'd0;
            end else if (cfg_lsb_first_i) begin
                r_shift_ch0 <= r_shift_ch0 >> 1;
                r_shift_ch1 <= r_shift_ch1 >> 1;
            end else begin
                r_shift_ch0 <= r_shift_ch0 << 1;
                r_shift_ch1 <= r_shift_ch1 << 1;
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx_channel.sv
// Bench for i2s_tx_channel: FIFO model plus a bit-level scoreboard fed
// with the words pushed into the FIFO and checked against the data lines.
module tb_i2s_tx_channel;

    logic        sck_i;
    logic        rstn_i;
    logic [31:0] fifo_data_i;
    logic        fifo_data_valid_i;
    logic        fifo_data_ready_o;
    logic        fifo_err_o;
    logic        i2s_ws_i;
    logic        i2s_ch0_o;
    logic        i2s_ch1_o;
    logic        cfg_en_i;
    logic        cfg_2ch_i;
    logic [4:0]  cfg_wlen_i;
    logic        cfg_lsb_first_i;

    i2s_tx_channel dut (
        .sck_i             (sck_i),
        .rstn_i            (rstn_i),
        .fifo_data_i       (fifo_data_i),
        .fifo_data_valid_i (fifo_data_valid_i),
        .fifo_data_ready_o (fifo_data_ready_o),
        .fifo_err_o        (fifo_err_o),
        .i2s_ws_i          (i2s_ws_i),
        .i2s_ch0_o         (i2s_ch0_o),
        .i2s_ch1_o         (i2s_ch1_o),
        .cfg_en_i          (cfg_en_i),
        .cfg_2ch_i         (cfg_2ch_i),
        .cfg_wlen_i        (cfg_wlen_i),
        .cfg_lsb_first_i   (cfg_lsb_first_i)
    );

    logic [31:0] fq[$];
    logic [31:0] exp_words[$];
    logic        q0[$];
    logic        q1[$];

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          t_ws = 0;
    int          seen_ws = -1;
    int          last_pop = 0;
    logic        run_en = 1'b0;
    logic        phase = 1'b0;
    logic [31:0] hold_w = 32'd0;
    logic        pend = 1'b0;

    initial begin
        sck_i = 1'b1;
        forever #5 sck_i = ~sck_i;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h",
                     tag, cyc, got, exp);
        end
    endtask

    // FIFO model: pop after the falling edge that consumed the head word
    always begin
        @(posedge sck_i);
        #1;
        fifo_data_valid_i = (fq.size() != 0);
        fifo_data_i = (fq.size() != 0) ? fq[0] : 32'hDEAD_BEEF;
        pend = fifo_data_ready_o;
        @(negedge sck_i);
        #1;
        if (pend && fq.size() != 0) void'(fq.pop_front());
        fifo_data_valid_i = (fq.size() != 0);
        fifo_data_i = (fq.size() != 0) ? fq[0] : 32'hDEAD_BEEF;
    end

    // Monitor and scoreboard, sampled 2 time units after the rising edge
    always @(posedge sck_i) begin
        logic        e0;
        logic        e1;
        logic        pop;
        logic [31:0] w;
        int          L;
        #2;
        cyc = cyc + 1;
        if (!rstn_i) begin
            check("rst_ch0", 32'(i2s_ch0_o), 32'd0);
            check("rst_ch1", 32'(i2s_ch1_o), 32'd0);
            check("rst_ready", 32'(fifo_data_ready_o), 32'd0);
            check("rst_err", 32'(fifo_err_o), 32'd0);
            q0.delete();
            q1.delete();
            phase = 1'b0;
        end else begin
            e0 = (q0.size() != 0) ? q0.pop_front() : 1'b0;
            e1 = (q1.size() != 0) ? q1.pop_front() : 1'b0;
            check("ch0_bit", 32'(i2s_ch0_o), 32'(e0));
            check("ch1_bit", 32'(i2s_ch1_o), 32'(e1));
            pop = fifo_data_ready_o;
            check("err", 32'(fifo_err_o), 32'(pop & ~fifo_data_valid_i));
            if (!run_en && cyc >= t_ws + 3)
                check("ready_idle", 32'(pop), 32'd0);
            if (pop) begin
                L = int'(cfg_wlen_i);
                w = 32'd0;
                if (fifo_data_valid_i && exp_words.size() != 0)
                    w = exp_words.pop_front();
                if (run_en) begin
                    if (seen_ws != t_ws) begin
                        check("latency", 32'(cyc - t_ws), 32'd3);
                        seen_ws = t_ws;
                    end else if (!cfg_2ch_i) begin
                        check("gap", 32'(cyc - last_pop), 32'(L + 1));
                    end else begin
                        check("gap", 32'(cyc - last_pop),
                              phase ? 32'd1 : 32'(L));
                    end
                end
                last_pop = cyc;
                if (!cfg_2ch_i) begin
                    for (int i = 0; i <= L; i++)
                        q0.push_back(cfg_lsb_first_i ? w[i] : w[L - i]);
                end else if (!phase) begin
                    hold_w = w;
                    phase = 1'b1;
                end else begin
                    for (int i = 0; i <= L; i++) begin
                        q0.push_back(cfg_lsb_first_i ? hold_w[i] : hold_w[L - i]);
                        q1.push_back(cfg_lsb_first_i ? w[i] : w[L - i]);
                    end
                    phase = 1'b0;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge sck_i);
        #3;
    endtask

    task automatic push(input logic [31:0] w);
        logic [31:0] m;
        m = 32'hFFFF_FFFF >> (5'd31 - cfg_wlen_i);
        fq.push_back(w);
        exp_words.push_back(w & m);
    endtask

    task automatic ws_toggle(input logic en);
        cfg_en_i = en;
        i2s_ws_i = ~i2s_ws_i;
        t_ws = cyc;
        run_en = en;
    endtask

    initial begin
        rstn_i = 1'b0;
        i2s_ws_i = 1'b0;
        cfg_en_i = 1'b0;
        cfg_2ch_i = 1'b0;
        cfg_wlen_i = 5'd15;
        cfg_lsb_first_i = 1'b0;
        tick(3);
        rstn_i = 1'b1;
        tick(5);

        // mono MSB-first, 16-bit words
        push(32'h0000_A5A5);
        push(32'h0000_1234);
        ws_toggle(1'b1);
        tick(40);
        ws_toggle(1'b0);
        tick(40);

        // stereo, 8-bit words
        cfg_2ch_i = 1'b1;
        cfg_wlen_i = 5'd7;
        push(32'h81);
        push(32'h3C);
        push(32'hFF);
        push(32'h00);
        ws_toggle(1'b1);
        tick(40);
        ws_toggle(1'b0);
        tick(40);

        // mono LSB-first, 5-bit words with junk above
        cfg_2ch_i = 1'b0;
        cfg_wlen_i = 5'd4;
        cfg_lsb_first_i = 1'b1;
        push(32'hABCD_E013);
        push(32'h1234_560A);
        ws_toggle(1'b1);
        tick(40);
        ws_toggle(1'b0);
        tick(40);

        // underrun then refill
        cfg_lsb_first_i = 1'b0;
        cfg_wlen_i = 5'd7;
        push(32'h5A);
        ws_toggle(1'b1);
        tick(22);
        push(32'hC3);
        push(32'h3C);
        tick(40);
        ws_toggle(1'b0);
        tick(40);

        // disable mid-frame takes effect only at the WS edge
        push(32'h11);
        push(32'h22);
        push(32'h44);
        push(32'h88);
        ws_toggle(1'b1);
        tick(12);
        cfg_en_i = 1'b0;
        tick(40);
        ws_toggle(1'b0);
        tick(40);

        // reset mid-word, then restart only on a new WS edge
        cfg_wlen_i = 5'd15;
        push(32'hFFFF);
        push(32'hFFFF);
        ws_toggle(1'b1);
        tick(10);
        rstn_i = 1'b0;
        i2s_ws_i = 1'b0;
        fq.delete();
        exp_words.delete();
        run_en = 1'b0;
        t_ws = cyc;
        tick(3);
        rstn_i = 1'b1;
        push(32'h1234);
        tick(30);
        ws_toggle(1'b1);
        tick(40);
        ws_toggle(1'b0);
        tick(40);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
